// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Buffered MIPS instruction-decode stage sitting between fetch and
// register-read. {pc, instruction} pairs arrive over a valid/ready handshake
// and are held in a DEPTH-entry FIFO. The head entry is decoded
// combinationally into R/I/J fields, sign- and zero-extended immediates, the
// absolute jump target and a coarse instruction class. A synchronous flush
// discards every buffered entry on a branch redirect.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. in_ready depends only on the fill level and never on
// out_ready, so a pop in the same cycle does not open a slot when full.
// out_valid depends only on the fill level.
//
// Parameters:
//   DEPTH  FIFO entries (>= 1, need not be a power of two)
//   PC_W   PC width (>= 28)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   in_valid     fetch offers an entry
//   in_ready     stage can accept an entry
//   in_instr     instruction word
//   in_pc        address of in_instr
//   flush        synchronous discard of all entries (highest priority)
//   out_valid    head entry valid
//   out_ready    downstream consumes the head entry
//   out_pc       head PC
//   opcode, rs, rt, rd, shamt, funct   instruction bit fields of the head
//   imm_sext     bits [15:0] sign-extended
//   imm_zext     bits [15:0] zero-extended
//   jump_target  {(out_pc+4)[PC_W-1:28], instr[25:0], 2'b00}
//   itype        00 = R, 10 = J, 01 = I
//   illegal      head opcode outside the legal set
//
// Configuration macro:
//   DECODE_STAGE_ILLEGAL_EN  when defined, illegal = out_valid && !legal(opcode);
//                            when undefined, illegal is tied to 0.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [31:0]     imm_sext,
    output logic [31:0]     imm_zext,
    output logic [PC_W-1:0] jump_target,
    output logic [1:0]      itype,
    output logic            illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q    [DEPTH];

    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Pointer / count next-state. Flush wins over any push or pop.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage. Cleared on reset so the decoded outputs read as zero
    // until the first entry arrives. A push dropped by flush is not stored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push && !flush) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Head decode: purely combinational from registered storage, so the
    // fields hold steady for as long as the head is not popped.
    // -------------------------------------------------------------------------
    logic [31:0] head_instr;

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign out_pc     = pc_mem_q[rd_ptr_q];

    assign opcode   = head_instr[31:26];
    assign rs       = head_instr[25:21];
    assign rt       = head_instr[20:16];
    assign rd       = head_instr[15:11];
    assign shamt    = head_instr[10:6];
    assign funct    = head_instr[5:0];
    assign imm_sext = {{16{head_instr[15]}}, head_instr[15:0]};
    assign imm_zext = {16'h0000, head_instr[15:0]};

    always_comb begin
        itype = 2'b01;
        if (opcode == 6'h00) begin
            itype = 2'b00;
        end else if ((opcode == 6'h02) || (opcode == 6'h03)) begin
            itype = 2'b10;
        end
    end

    // Only the bits of pc+4 above bit 27 reach the jump target. Adding 4
    // carries into bit 28 exactly when bits [27:2] are all ones, so the
    // upper slice is computed directly rather than forming the full sum.
    generate
        if (PC_W > 28) begin : g_jt_upper
            logic [PC_W-29:0] pc_hi_plus4;
            assign pc_hi_plus4 = out_pc[PC_W-1:28]
                               + {{(PC_W-29){1'b0}}, &out_pc[27:2]};
            assign jump_target = {pc_hi_plus4, head_instr[25:0], 2'b00};
        end else begin : g_jt_flat
            assign jump_target = {head_instr[25:0], 2'b00};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Illegal-opcode flag
    // -------------------------------------------------------------------------
`ifdef DECODE_STAGE_ILLEGAL_EN
    function automatic logic legal_opcode(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        if (op[5:4] == 2'b00) begin
            ok = 1'b1;                      // 0x00 .. 0x0F
        end else begin
            case (op)
                6'h20, 6'h21, 6'h23, 6'h24,
                6'h25, 6'h28, 6'h29, 6'h2B: ok = 1'b1;
                default:                    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign illegal = out_valid && !legal_opcode(opcode);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage (DEPTH = 2, PC_W = 32). Inputs change 1 ns
// after the rising edge and outputs are sampled there too. Every expected
// value below is worked out by hand from the instruction encodings.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [31:0]     imm_sext;
    logic [31:0]     imm_zext;
    logic [PC_W-1:0] jump_target;
    logic [1:0]      itype;
    logic            illegal;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {pc, instr} pairs for the in-order drain check.
    logic [63:0] exp_q[$];

    decode_stage #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm_sext    (imm_sext),
        .imm_zext    (imm_zext),
        .jump_target (jump_target),
        .itype       (itype),
        .illegal     (illegal)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checker and drivers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Rebuild an I-type word from the decoded fields.
    function automatic logic [31:0] head_word();
        return {opcode, rs, rt, imm_zext[15:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [63:0] e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // ---- reset / idle ----
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_pc",    out_pc, 0);
        check("rst_opcode",    opcode, 0);
        check("rst_rs_rt_rd",  {rs, rt, rd, shamt, funct}, 0);
        check("rst_imm",       {imm_sext, imm_zext}, 0);
        check("rst_jt",        jump_target, 0);
        check("rst_itype",     itype, 0);
        check("rst_illegal",   illegal, 0);

        // ---- R-type: add $8,$9,$10 ----
        push_one(32'h012A4020, 32'h0040_0000);
        check("r_out_valid", out_valid, 1);
        check("r_itype",     itype, 2'b00);
        check("r_opcode",    opcode, 6'h00);
        check("r_rs",        rs, 9);
        check("r_rt",        rt, 10);
        check("r_rd",        rd, 8);
        check("r_shamt",     shamt, 0);
        check("r_funct",     funct, 6'h20);
        check("r_out_pc",    out_pc, 32'h0040_0000);
        check("r_jt",        jump_target, 32'h04A9_0080);
        check("r_illegal",   illegal, 0);
        pop_one();
        check("r_popped",    out_valid, 0);

        // ---- I-type: lw $9,-4($8) ----
        push_one(32'h8D09FFFC, 32'h0040_0004);
        check("i_opcode",   opcode, 6'h23);
        check("i_rs",       rs, 8);
        check("i_rt",       rt, 9);
        check("i_imm_sext", imm_sext, 32'hFFFF_FFFC);
        check("i_imm_zext", imm_zext, 32'h0000_FFFC);
        check("i_itype",    itype, 2'b01);
        check("i_rd_shamt", {rd, shamt, funct}, {5'd31, 5'd31, 6'h3C});
        pop_one();

        // ---- J-type ----
        push_one(32'h08000010, 32'h9000_0000);
        check("j_itype", itype, 2'b10);
        check("j_jt",    jump_target, 32'h9000_0040);
        pop_one();

        // jal at the top of the address space: pc+4 wraps to 0
        push_one(32'h0C000001, 32'hFFFF_FFFC);
        check("jal_itype", itype, 2'b10);
        check("jal_jt_wrap", jump_target, 32'h0000_0004);
        pop_one();

        // ---- back-pressure: fill, hold off third, drain in order ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h20010001; in_pc = 32'h0000_0100;
        exp_q.push_back({32'h0000_0100, 32'h20010001});
        step();
        check("fill1_in_ready", in_ready, 1);
        in_instr  = 32'h20020002; in_pc = 32'h0000_0104;
        exp_q.push_back({32'h0000_0104, 32'h20020002});
        step();
        check("fill2_in_ready",  in_ready, 0);
        check("fill2_out_valid", out_valid, 1);
        in_instr  = 32'h20030003; in_pc = 32'h0000_0108;
        for (int i = 0; i < 2; i++) begin
            step();
            check("full_in_ready", in_ready, 0);
            check("full_head_pc",  out_pc, 32'h0000_0100);
            check("full_head_imm", imm_zext, 32'h0000_0001);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("drain_valid", out_valid, 1);
            check("drain_pc",    out_pc, e[63:32]);
            check("drain_instr", head_word(), e[31:0]);
            step();
        end
        out_ready = 1'b0;
        check("drain_empty",    out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        // ---- streaming: push and pop in the same cycle ----
        push_one(32'h20040004, 32'h0000_0200);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h20050005; in_pc = 32'h0000_0204;
        step();
        check("stream1_valid", out_valid, 1);
        check("stream1_pc",    out_pc, 32'h0000_0204);
        check("stream1_ready", in_ready, 1);
        in_instr  = 32'h20060006; in_pc = 32'h0000_0208;
        step();
        check("stream2_word",  head_word(), 32'h20060006);
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_empty",  out_valid, 0);

        // ---- flush while full, with a push and a pop offered ----
        push_one(32'h20070007, 32'h0000_0300);
        push_one(32'h20080008, 32'h0000_0304);
        check("pre_flush_full", in_ready, 0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h20090009; in_pc = 32'h0000_0308;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready",  in_ready, 1);
        step();
        check("flush_stays_empty", out_valid, 0);
        push_one(32'h200A000A, 32'h0000_0400);
        check("post_flush_pc",  out_pc, 32'h0000_0400);
        check("post_flush_imm", imm_zext, 32'h0000_000A);
        pop_one();
        check("post_flush_empty", out_valid, 0);

        // ---- illegal opcode flag ----
        push_one(32'hFC000000, 32'h0000_0500);
`ifdef DECODE_STAGE_ILLEGAL_EN
        check("illegal_3f", illegal, 1);
`else
        check("illegal_3f", illegal, 0);
`endif
        pop_one();
        push_one(32'h8D09FFFC, 32'h0000_0504);
        check("illegal_23", illegal, 0);
        pop_one();

        // ---- asynchronous reset mid-cycle ----
        push_one(32'h200B000B, 32'h0000_0600);
        check("pre_arst_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready",  in_ready, 1);
        check("arst_out_pc",    out_pc, 0);
        check("arst_imm",       imm_zext, 0);
        #2;
        rst = 1'b0;
        step();
        check("arst_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Buffered, parametrised MIPS instruction-decode stage between fetch and register-read. It accepts `{pc, instruction}` pairs over a valid/ready handshake and holds them in a DEPTH-entry FIFO. The head entry is presented as split R/I/J fields plus sign- and zero-extended immediates, absolute jump target and instruction class. The FIFO absorbs back-pressure, and `flush` discards in-flight entries on branch redirect.

## Interface
- `DEPTH`, default 2: FIFO entries, ≥1. Any value is legal; pointers wrap at DEPTH.
- `PC_W`, default 32: PC width, ≥28.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch offers an entry.
- `in_ready`  out  1  stage can accept an entry.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  address of `in_instr`.
- `flush`  in  1  synchronous discard of all entries.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head.
- `out_pc`  out  PC_W  head PC.
- `opcode`  out  6  bits [31:26].
- `rs`  out  5  bits [25:21].
- `rt`  out  5  bits [20:16].
- `rd`  out  5  bits [15:11].
- `shamt`  out  5  bits [10:6].
- `funct`  out  6  bits [5:0].
- `imm_sext`  out  32  bits [15:0], sign-extended.
- `imm_zext`  out  32  bits [15:0], zero-extended.
- `jump_target`  out  PC_W  `{(out_pc+4)[PC_W-1:28], instr[25:0], 2'b00}`.
- `itype`  out  2  00 = R (opcode 0); 10 = J (opcode 2 or 3); 01 = I (all other opcodes).
- `illegal`  out  1  opcode not in the legal set (see Configuration).

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. There is no pass-through when full: a pop in the same cycle does not raise `in_ready`.
- `out_valid = (count != 0)`.
- Simultaneous push and pop with `0 < count < DEPTH`: count is unchanged and both pointers advance.
- Push into an empty FIFO: the entry is visible at the outputs the next cycle.
- Read and write pointers wrap from DEPTH-1 to 0. `count` is `$clog2(DEPTH+1)` bits wide.
- All field outputs decode combinationally from the registered head-entry storage, never from `in_instr`.
- Field outputs are stable while `out_valid && !out_ready`.
- `flush` has priority over everything:
  - count and pointers clear;
  - a push offered in the same cycle is dropped;
  - a pop in the same cycle is ignored;
  - `out_valid` is 0 the next cycle.
- `jump_target` addition is modulo 2^PC_W. Only the upper PC bits of `pc+4` are used.

## Timing
- Reset (async assert, sync release):
  - pointers, count and storage cleared to 0;
  - `out_valid` = 0 and `in_ready` = 1;
  - every field output is 0, `itype` = 00 and `illegal` = 0;
  - `out_pc` = 0;
  - `jump_target` = 0 when PC_W = 32; in general it is 0 except for the `(0+4)` upper bits.
- Latency: 1 cycle from accepted push to `out_valid` on an empty FIFO.
- Throughput: 1 entry per cycle while not full.
- Reset asserted mid-operation empties the FIFO immediately, without waiting for a clock edge.

## Configuration
- Macro: `DECODE_STAGE_ILLEGAL_EN`.
- Defined:
  - `illegal` = `out_valid && !legal(opcode)`;
  - legal opcodes are 0x00–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29 and 0x2B.
- Undefined: `illegal` is tied to 0, and no legal-set logic is synthesised.

## Test plan
- Reset, then idle → `out_valid` = 0, `in_ready` = 1, all fields 0.
- Push 0x012A4020 at pc 0x00400000 → next cycle:
  - `out_valid` = 1, `itype` = 00;
  - `opcode` = 0, `rs` = 9, `rt` = 10, `rd` = 8, `shamt` = 0, `funct` = 0x20.
- Push 0x8D09FFFC → `opcode` = 0x23, `rs` = 8, `rt` = 9, `imm_sext` = 0xFFFFFFFC, `imm_zext` = 0x0000FFFC, `itype` = 01.
- Push 0x08000010 at pc 0x90000000 → `itype` = 10, `jump_target` = 0x90000040.
- DEPTH = 2, `out_ready` = 0, push 3 entries → `in_ready` drops after 2, the third is held off, and the head is unchanged. Raise `out_ready` → entries pop in order with no loss.
- FIFO full, then assert `flush` with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and the offered entry never appears.
- With `DECODE_STAGE_ILLEGAL_EN` defined: push opcode 0x3F → `illegal` = 1. Push 0x23 → `illegal` = 0.
